// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: shares the CPU memory path with a 256-byte page-to-OAM copy engine.
// Optional macro OAM_DMA_ALIGN_EN enables the parity-driven ALIGN cycle after HALT.
module oam_dma_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_busy,
    output logic        dma_done,
    output logic [2:0]  state_dbg,
    output logic        parity_dbg
);

    // Handshake: a CPU access completes in a cycle with cpu_req && cpu_rdy; while
    // cpu_rdy is low the CPU holds its request and the arbiter ignores every CPU input.

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] index;
    logic [7:0] page;
    logic       parity;
    logic       trigger;

    assign trigger    = (state == ST_IDLE) && cpu_req && cpu_we && (cpu_addr == DMA_TRIG_ADDR);
    assign cpu_rdata  = mem_rdata;
    assign dma_busy   = (state != ST_IDLE);
    assign state_dbg  = state;
    assign parity_dbg = parity;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            index  <= 8'h00;
            page   <= 8'h00;
            parity <= 1'b0;
        end else begin
            state  <= state_nxt;
            parity <= ~parity;
            if (trigger) begin
                page <= cpu_wdata;
            end
            if (state == ST_WRITE) begin
                index <= (index == 8'hFF) ? 8'h00 : index + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_rdy   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        dma_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                // The trigger write itself is forwarded so the decoder still sees it.
                cpu_rdy   = 1'b1;
                mem_req   = cpu_req;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                if (trigger) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_nxt = parity ? ST_ALIGN : ST_READ;
`else
                state_nxt = ST_READ;
`endif
            end
            ST_ALIGN: begin
                state_nxt = ST_READ;
            end
            ST_READ: begin
                mem_req   = 1'b1;
                mem_addr  = {page, index};
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                // Memory has one-cycle read latency, so mem_rdata holds the byte from READ.
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = OAM_DATA_ADDR;
                mem_wdata = mem_rdata;
                if (index == 8'hFF) begin
                    dma_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_READ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: passthrough, non-triggers, full transfers,
// back-to-back trigger and mid-transfer reset. Honours OAM_DMA_ALIGN_EN if defined.
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        dma_busy;
    logic        dma_done;
    logic [2:0]  state_dbg;
    logic        parity_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt;
    logic [1:0] seen_par = 2'b00;

    oam_dma_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rdy    (cpu_rdy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dma_busy   (dma_busy),
        .dma_done   (dma_done),
        .state_dbg  (state_dbg),
        .parity_dbg (parity_dbg)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    // Memory contents: page 3 gives i^A5 at offset i.
    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA6;
    endfunction

    always @(posedge clk) begin
        if (mem_req && !mem_we) mem_rdata <= mem_fn(mem_addr);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver: one DMA transfer ----------------
    // Entered mid-cycle with inputs free to drive; returns in the first IDLE cycle.
    task automatic run_dma(input logic [7:0] page, input int abort_after);
        int stall, writes, dones, aligns, halt_par, exp_stall;
        logic [7:0] idx;
        logic [7:0] exp_data;
        logic exp_we;
        logic done_loop;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = page;
        #1;
        check("trig_rdy", cpu_rdy, 1);
        check("trig_busy", dma_busy, 0);
        check("trig_fwd_addr", mem_addr, 16'h4014);
        check("trig_fwd_we", mem_we, 1);
        @(negedge clk);
        cpu_wdata = ~page;
        #1;
        check("halt_state", state_dbg, 1);
        check("halt_rdy", cpu_rdy, 0);
        check("halt_busy", dma_busy, 1);
        check("halt_mem_req", mem_req, 0);
        check("halt_parity", parity_dbg, edge_cnt % 2);
        halt_par = edge_cnt % 2;
        seen_par[halt_par] = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
        exp_stall = (halt_par == 1) ? 514 : 513;
`else
        exp_stall = 513;
`endif
        stall = 1; writes = 0; dones = 0; aligns = 0; idx = 8'h00; exp_we = 1'b0;
        done_loop = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (stall == 8) begin
                cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
            end
            #1;
            if (abort_after != 0 && writes == abort_after) begin
                reset_n = 1'b0;
                #1;
                check("rst_rdy", cpu_rdy, 1);
                check("rst_busy", dma_busy, 0);
                check("rst_done", dma_done, 0);
                check("rst_state", state_dbg, 0);
                check("rst_parity", parity_dbg, 0);
                check("rst_mem_req", mem_req, 0);
                cpu_req = 1'b1; cpu_addr = 16'h1234;
                #1;
                check("rst_fwd_addr", mem_addr, 16'h1234);
                check("rst_fwd_req", mem_req, 1);
                cpu_req = 1'b0; cpu_addr = 16'h0000;
                @(negedge clk);
                reset_n = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    #1;
                    check("post_rst_idle", dma_busy, 0);
                    check("post_rst_no_mem", mem_req, 0);
                end
                return;
            end
            if (cpu_rdy) begin
                done_loop = 1'b1;
                break;
            end
            stall++;
            if (dma_done) dones++;
            if (!mem_req) begin
                aligns++;
                check("align_state", state_dbg, 2);
            end else begin
                check("rw_order", mem_we, exp_we);
                exp_we = ~exp_we;
                if (!mem_we) begin
                    check("read_addr", mem_addr, {page, idx});
                end else begin
                    exp_data = (page == 8'h03) ? (idx ^ 8'hA5) : mem_fn({page, idx});
                    check("wr_addr", mem_addr, 16'h2004);
                    check("wr_data", mem_wdata, exp_data);
                    check("wr_done", dma_done, idx == 8'hFF);
                    idx++;
                    writes++;
                end
            end
        end
        check("no_timeout", done_loop, 1);
        check("stall_len", stall, exp_stall);
        check("write_count", writes, 256);
        check("done_pulses", dones, 1);
        check("align_cycles", aligns, exp_stall - 513);
        check("end_busy", dma_busy, 0);
        check("end_state", state_dbg, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] nt_addr [3];
    logic        nt_we   [3];

    initial begin
        nt_addr[0] = 16'h4014; nt_we[0] = 1'b0;
        nt_addr[1] = 16'h4015; nt_we[1] = 1'b1;
        nt_addr[2] = 16'h2014; nt_we[2] = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("reset_rdy", cpu_rdy, 1);
        check("reset_busy", dma_busy, 0);
        check("reset_done", dma_done, 0);
        check("reset_state", state_dbg, 0);
        check("reset_parity", parity_dbg, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // IDLE passthrough read
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0800;
        #1;
        check("idle_addr", mem_addr, 16'h0800);
        check("idle_req", mem_req, 1);
        check("idle_we", mem_we, 0);
        check("idle_rdy", cpu_rdy, 1);
        @(negedge clk);
        cpu_req = 1'b0; cpu_addr = 16'h0000;
        #1;
        check("idle_rdata", cpu_rdata, 8'hAE);

        // Accesses that must not start a transfer
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = nt_we[i]; cpu_addr = nt_addr[i]; cpu_wdata = 8'h5A;
            #1;
            check("nt_busy", dma_busy, 0);
            check("nt_rdy", cpu_rdy, 1);
            check("nt_wdata", mem_wdata, 8'h5A);
        end
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        #1;
        check("nt_busy_after", dma_busy, 0);
        @(negedge clk);
        #1;
        check("nt_state_after", state_dbg, 0);

        // Full transfer, then an immediate retrigger in the first IDLE cycle
        @(negedge clk);
        run_dma(8'h02, 0);
        run_dma(8'h03, 0);

        // Pick a cycle so the HALT parity not yet exercised gets covered
        @(negedge clk);
        if (seen_par[(edge_cnt + 1) % 2]) @(negedge clk);
        run_dma(8'h20, 0);

        // Reset after 100 OAM writes, then retrigger from index 0
        @(negedge clk);
        run_dma(8'h40, 100);
        @(negedge clk);
        run_dma(8'h05, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
